// File: rtl/cache_line_refill.sv
// cache_line_refill: refills one 16-byte cache line on a read miss.
// The controller fetches the four 32-bit words over a req/ack word interface,
// forwards the requested (critical) word as soon as it arrives, and then
// presents the complete line for a single-cycle write into the cache array.
//
// Optional feature macro: REFILL_CRIT_FIRST_EN
//   defined   - the fetch starts at the missing word and wraps (critical word first)
//   undefined - the fetch always runs 0,1,2,3
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a miss; miss_ready high
// FETCH | one word request outstanding at {tag, index, cur_off, 00}
// FILL  | fill_valid pulse; the line is written into the cache
module cache_line_refill #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_WIDTH     = 8,
  parameter int LINE_WIDTH    = 137
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_valid,
  input  logic [ADDRESS_WIDTH-1:0]      miss_addr,
  output logic                          miss_ready,
  output logic                          mem_req,
  output logic [ADDRESS_WIDTH-1:0]      mem_addr,
  input  logic                          mem_ack,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic                          crit_valid,
  output logic [DATA_WIDTH-1:0]         crit_data,
  output logic                          fill_valid,
  output logic [ADDRESS_WIDTH-TAG_WIDTH-5:0] fill_index,
  output logic [LINE_WIDTH-1:0]         fill_line,
  output logic                          busy
);

  localparam int LINE_ADDR_WIDTH = ADDRESS_WIDTH - 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

  state_t                          state;
  logic [LINE_ADDR_WIDTH-1:0]      line_addr;
  logic [1:0]                      cur_off;
  logic [1:0]                      crit_off;
  logic [1:0]                      word_cnt;
  logic [3:0][DATA_WIDTH-1:0]      line_words;
  logic                            line_valid;
  logic [1:0]                      start_off;
  logic                            byte_off_unused;

  // Loads are formatted downstream from crit_data, so the byte offset plays no part here.
  assign byte_off_unused = ^miss_addr[1:0];

  // First slot to fetch: the missing word itself, or always slot 0.
`ifdef REFILL_CRIT_FIRST_EN
  assign start_off = miss_addr[3:2];
`else
  assign start_off = 2'b00;
`endif

  // Request address is rebuilt from the latched line address, so it cannot move during a stall.
  assign mem_addr   = {line_addr, cur_off, 2'b00};
  assign fill_index = line_addr[LINE_ADDR_WIDTH-TAG_WIDTH-1:0];
  assign fill_line  = {line_valid, line_addr[LINE_ADDR_WIDTH-1 -: TAG_WIDTH], line_words};

  // Refill sequencer: accept, fetch four words in wrap order, then pulse the fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      line_addr  <= '0;
      cur_off    <= '0;
      crit_off   <= '0;
      word_cnt   <= '0;
      line_words <= '0;
      line_valid <= 1'b0;
      miss_ready <= 1'b1;
      mem_req    <= 1'b0;
      busy       <= 1'b0;
      crit_valid <= 1'b0;
      crit_data  <= '0;
      fill_valid <= 1'b0;
    end else begin
      crit_valid <= 1'b0;
      fill_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (miss_valid && miss_ready) begin
            line_addr  <= miss_addr[ADDRESS_WIDTH-1:4];
            crit_off   <= miss_addr[3:2];
            cur_off    <= start_off;
            word_cnt   <= '0;
            line_valid <= 1'b0;
            miss_ready <= 1'b0;
            mem_req    <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (mem_ack) begin
            line_words[cur_off] <= mem_rdata;
            if (cur_off == crit_off) begin
              crit_data  <= mem_rdata;
              crit_valid <= 1'b1;
            end
            cur_off  <= cur_off + 2'd1;
            word_cnt <= word_cnt + 2'd1;
            if (word_cnt == 2'd3) begin
              mem_req    <= 1'b0;
              line_valid <= 1'b1;
              fill_valid <= 1'b1;
              state      <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          miss_ready <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          miss_ready <= 1'b1;
          mem_req    <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_refill.sv
// Testbench for cache_line_refill: scoreboard of expected memory addresses,
// critical words and fill lines, plus per-scenario timing checks.
module tb_cache_line_refill;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         miss_valid = 1'b0;
  logic [15:0]  miss_addr = '0;
  logic         miss_ready;
  logic         mem_req;
  logic [15:0]  mem_addr;
  logic         mem_ack = 1'b0;
  logic [31:0]  mem_rdata;
  logic         crit_valid;
  logic [31:0]  crit_data;
  logic         fill_valid;
  logic [3:0]   fill_index;
  logic [136:0] fill_line;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int stall_cycles = 0;
  logic ack_always = 1'b0;
  int wcnt = 0;
  logic prev_req = 1'b0;

  logic [15:0]  addr_q[$];
  logic [31:0]  crit_q[$];
  logic [140:0] fill_q[$];

  localparam logic [136:0] LINE_12A8 =
    {1'b1, 8'h12, 32'h000012AC, 32'h000012A8, 32'h000012A4, 32'h000012A0};

  cache_line_refill dut (
    .clk        (clk),
    .rst        (rst),
    .miss_valid (miss_valid),
    .miss_addr  (miss_addr),
    .miss_ready (miss_ready),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .crit_valid (crit_valid),
    .crit_data  (crit_data),
    .fill_valid (fill_valid),
    .fill_index (fill_index),
    .fill_line  (fill_line),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory returns its own word address as data.
  assign mem_rdata = {16'h0000, mem_addr};

  // Memory responder: stall_cycles idle cycles before each ack.
  always begin
    @(posedge clk);
    #1;
    if (prev_req && mem_ack) wcnt = 0;
    else if (prev_req) wcnt++;
    if (!mem_req) wcnt = 0;
    mem_ack = ack_always || (mem_req && (wcnt >= stall_cycles));
    prev_req = mem_req;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req) begin
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL mem_addr_unexpected got=%h", mem_addr);
        end else begin
          if (mem_addr !== addr_q[0]) begin
            errors++;
            $display("FAIL mem_addr got=%h expected=%h", mem_addr, addr_q[0]);
          end
          if (mem_ack) void'(addr_q.pop_front());
        end
      end
      if (crit_valid) begin
        checks++;
        if (crit_q.size() == 0) begin
          errors++;
          $display("FAIL crit_unexpected got=%h", crit_data);
        end else begin
          if (crit_data !== crit_q[0]) begin
            errors++;
            $display("FAIL crit_data got=%h expected=%h", crit_data, crit_q[0]);
          end
          void'(crit_q.pop_front());
        end
      end
      if (fill_valid) begin
        checks++;
        if (fill_q.size() == 0) begin
          errors++;
          $display("FAIL fill_unexpected got=%h", {fill_index, fill_line});
        end else begin
          if ({fill_index, fill_line} !== fill_q[0]) begin
            errors++;
            $display("FAIL fill_line got=%h expected=%h", {fill_index, fill_line}, fill_q[0]);
          end
          void'(fill_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input logic [15:0] a);
    logic [15:0]  base;
    logic [1:0]   start;
    logic [1:0]   k;
    logic [127:0] words;
    base = {a[15:4], 4'h0};
`ifdef REFILL_CRIT_FIRST_EN
    start = a[3:2];
`else
    start = 2'b00;
`endif
    for (int i = 0; i < 4; i++) begin
      k = start + 2'(i);
      addr_q.push_back(base | {12'h000, k, 2'b00});
    end
    crit_q.push_back({16'h0000, base | {12'h000, a[3:2], 2'b00}});
    for (int j = 0; j < 4; j++) begin
      words[32*j +: 32] = {16'h0000, base | 16'(j * 4)};
    end
    fill_q.push_back({a[7:4], 1'b1, a[15:8], words});
  endtask

  task automatic start_miss(input logic [15:0] a, output int acc);
    push_expect(a);
    miss_addr = a;
    miss_valid = 1'b1;
    step();
    miss_valid = 1'b0;
    acc = cyc;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL accept addr=%h busy=%b expected=1", a, busy);
    end
  endtask

  // Steps until fill_valid is seen (or the budget runs out); returns observation cycles.
  task automatic run_to_fill(input int budget, output int crit_at, output int fill_at);
    crit_at = -1;
    fill_at = -1;
    for (int i = 0; i < budget && fill_at < 0; i++) begin
      if (crit_valid && crit_at < 0) crit_at = cyc;
      if (fill_valid) fill_at = cyc;
      else step();
    end
    if (crit_valid && crit_at < 0) crit_at = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    miss_valid = 1'b1;
    miss_addr = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({miss_ready, mem_req, fill_valid, crit_valid, busy} !== 5'b10000) begin
        errors++;
        $display("FAIL reset_outputs got ready/req/fill/crit/busy=%b expected=10000",
                 {miss_ready, mem_req, fill_valid, crit_valid, busy});
      end
      checks++;
      if ({fill_line, crit_data, mem_addr} !== '0) begin
        errors++;
        $display("FAIL reset_data got line=%h crit=%h addr=%h expected=0",
                 fill_line, crit_data, mem_addr);
      end
    end
    miss_valid = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept busy=%b expected=0", busy);
    end
  endtask

  task automatic test_ack_idle();
    ack_always = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({busy, mem_req, fill_valid, crit_valid, miss_ready} !== 5'b00001) begin
        errors++;
        $display("FAIL ack_idle got busy/req/fill/crit/ready=%b expected=00001",
                 {busy, mem_req, fill_valid, crit_valid, miss_ready});
      end
    end
    ack_always = 1'b0;
    step();
  endtask

  task automatic test_crit_wrap();
    int acc, crit_at, fill_at, exp_crit;
    stall_cycles = 0;
    start_miss(16'h12A8, acc);
    run_to_fill(20, crit_at, fill_at);
`ifdef REFILL_CRIT_FIRST_EN
    exp_crit = acc + 1;
`else
    exp_crit = acc + 3;
`endif
    checks++;
    if (fill_at != acc + 4) begin
      errors++;
      $display("FAIL wrap_fill_time got=%0d expected=%0d", fill_at - acc, 4);
    end
    checks++;
    if (crit_at != exp_crit) begin
      errors++;
      $display("FAIL wrap_crit_time got=%0d expected=%0d", crit_at - acc, exp_crit - acc);
    end
    checks++;
    if (fill_index !== 4'hA || fill_line !== LINE_12A8) begin
      errors++;
      $display("FAIL wrap_line got idx=%h line=%h expected idx=a line=%h",
               fill_index, fill_line, LINE_12A8);
    end
    checks++;
    if (miss_ready !== 1'b0) begin
      errors++;
      $display("FAIL wrap_ready_in_fill got=%b expected=0", miss_ready);
    end
    step();
    checks++;
    if (miss_ready !== 1'b1 || fill_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_after_fill got ready=%b fill=%b expected 1 0", miss_ready, fill_valid);
    end
    checks++;
    if (fill_line !== LINE_12A8 || crit_data !== 32'h000012A8) begin
      errors++;
      $display("FAIL wrap_hold got line=%h crit=%h", fill_line, crit_data);
    end
  endtask

  task automatic test_stall();
    int acc, crit_at, fill_at, exp_crit;
    stall_cycles = 3;
    start_miss(16'h0034, acc);
    run_to_fill(40, crit_at, fill_at);
`ifdef REFILL_CRIT_FIRST_EN
    exp_crit = acc + 4;
`else
    exp_crit = acc + 8;
`endif
    checks++;
    if (fill_at != acc + 16) begin
      errors++;
      $display("FAIL stall_fill_time got=%0d expected=16", fill_at - acc);
    end
    checks++;
    if (crit_at != exp_crit) begin
      errors++;
      $display("FAIL stall_crit_time got=%0d expected=%0d", crit_at - acc, exp_crit - acc);
    end
    step();
    checks++;
    if (fill_valid !== 1'b0 || miss_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_single_pulse got fill=%b ready=%b expected 0 1", fill_valid, miss_ready);
    end
    stall_cycles = 0;
    step();
  endtask

  task automatic test_reset_mid_fetch();
    int acc, crit_at, fill_at;
    stall_cycles = 0;
    start_miss(16'h020C, acc);
    step();
    step();
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, busy, miss_ready} !== 3'b001) begin
      errors++;
      $display("FAIL midreset_async got req/busy/ready=%b expected=001", {mem_req, busy, miss_ready});
    end
    addr_q.delete();
    crit_q.delete();
    fill_q.delete();
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({fill_valid, crit_valid, busy, mem_req} !== 4'b0000) begin
        errors++;
        $display("FAIL midreset_quiet got fill/crit/busy/req=%b expected=0000",
                 {fill_valid, crit_valid, busy, mem_req});
      end
    end
    start_miss(16'h0100, acc);
    run_to_fill(20, crit_at, fill_at);
    checks++;
    if (fill_at != acc + 4) begin
      errors++;
      $display("FAIL midreset_refill_time got=%0d expected=4", fill_at - acc);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, fill1, crit_at, fill_at;
    logic r;
    stall_cycles = 0;
    push_expect(16'h4440);
    push_expect(16'h5550);
    miss_addr = 16'h4440;
    miss_valid = 1'b1;
    step();
    acc1 = cyc;
    miss_addr = 16'h5550;
    acc2 = -1;
    fill1 = -1;
    for (int i = 0; i < 20 && acc2 < 0; i++) begin
      r = miss_ready;
      step();
      if (fill_valid && fill1 < 0) fill1 = cyc;
      if (r && busy) acc2 = cyc;
    end
    miss_valid = 1'b0;
    checks++;
    if (fill1 != acc1 + 4) begin
      errors++;
      $display("FAIL b2b_first_fill got=%0d expected=4", fill1 - acc1);
    end
    checks++;
    if (acc2 != acc1 + 6) begin
      errors++;
      $display("FAIL b2b_spacing got=%0d expected=6", acc2 - acc1);
    end
    run_to_fill(20, crit_at, fill_at);
    checks++;
    if (fill_at != acc2 + 4) begin
      errors++;
      $display("FAIL b2b_second_fill got=%0d expected=4", fill_at - acc2);
    end
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_ack_idle();
    test_crit_wrap();
    test_stall();
    test_reset_mid_fetch();
    test_back_to_back();
    checks++;
    if (addr_q.size() != 0 || crit_q.size() != 0 || fill_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got addr=%0d crit=%0d fill=%0d expected 0 0 0",
               addr_q.size(), crit_q.size(), fill_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_line_refill.md
# cache_line_refill

Line-refill controller between the direct-mapped data cache and byte-addressed main memory. On a read miss it fetches the four 32-bit words of the missing 16-byte line over a req/ack word interface, forwards the requested (critical) word as soon as it arrives, then presents a complete 137-bit cache line for a single-cycle write into the cache array. It replaces the combinational four-word neighbour fetch with a multi-cycle, memory-latency-tolerant refill.

## Interface
- `ADDRESS_WIDTH`, default 16: byte address width. Address fields are: [15:8] tag, [7:4] index, [3:2] word offset, [1:0] byte offset.
- `DATA_WIDTH`, default 32: word width.
- `TAG_WIDTH`, default 8: tag width.
- `LINE_WIDTH`, default 137: cache line width, packed as {valid, tag, w3, w2, w1, w0}.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `miss_valid` in 1: the cache requests a refill.
- `miss_addr` in 16: byte address of the missing load.
- `miss_ready` out 1: high only in IDLE. A miss is accepted on an edge where `miss_valid` and `miss_ready` are both high.
- `mem_req` out 1: word read request to main memory.
- `mem_addr` out 16: word-aligned address; bits [1:0] are always 00.
- `mem_ack` in 1: memory returns `mem_rdata` this cycle. It may be asserted in the same cycle `mem_req` rises.
- `mem_rdata` in 32: returned word.
- `crit_valid` out 1: one-cycle pulse; `crit_data` holds the requested word.
- `crit_data` out 32: the critical word; held stable until the next miss is accepted.
- `fill_valid` out 1: one-cycle pulse; the cache writes `fill_line` at `fill_index`.
- `fill_index` out 4: equals `miss_addr[7:4]` of the latched miss.
- `fill_line` out 137: {1'b1, `miss_addr[15:8]`, w3, w2, w1, w0}.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **States:** IDLE, FETCH, FILL.
- **IDLE:**
  - `miss_ready`=1.
  - On an accepted miss: latch `miss_addr`, set the start offset, clear the word count, go to FETCH.
- **FETCH:**
  - `mem_req`=1.
  - `mem_addr`={tag, index, cur_off, 2'b00}, held stable until `mem_ack`.
  - On `mem_ack`: write `mem_rdata` into line slot `cur_off`, then `cur_off`=`cur_off`+1 mod 4 and count+1.
  - After the 4th ack, go to FILL.
- **Line packing:** slot k always occupies `fill_line`[32k+31:32k], whatever the fetch order.
- **Critical word:** when the captured `cur_off` equals the latched `miss_addr[3:2]`, load `crit_data` and pulse `crit_valid` in the following cycle.
- **FILL:** `fill_valid`=1 for exactly one cycle, `mem_req`=0, `miss_ready`=0. Next state is IDLE unconditionally.
- **miss_valid during FETCH or FILL:** ignored, not queued. The cache holds the request, and it is accepted in IDLE.
- **Byte offset:** `miss_addr[1:0]` is ignored. Formatting of byte and halfword loads is done downstream from `crit_data`.
- **mem_ack outside FETCH:** ignored; no state change.

## Timing
- **Reset values:** all outputs 0 except `miss_ready`=1. State IDLE, line buffer 0, count 0.
- **Reset mid-FETCH:** `mem_req` drops immediately (asynchronously). The partial line is discarded, and no `fill_valid` or `crit_valid` is issued.
- **Minimum latency** (acks in every FETCH cycle):
  - accept at edge E0;
  - words captured at E1 through E4;
  - `fill_valid` high in cycle E4–E5;
  - `miss_ready` high again from E5.
- **Critical word timing:** with critical-word-first ordering, `crit_valid` is high in cycle E1–E2.
- **Memory stalls:** each cycle of `mem_ack`=0 in FETCH adds one cycle. `mem_addr` must not change while waiting.
- **fill_index / fill_line stability:** valid in the `fill_valid` cycle; they hold their values until the next miss is accepted.
- **Back-to-back misses:** the minimum spacing between accepted misses is 6 cycles.

## Configuration
- `REFILL_CRIT_FIRST_EN`:
  - **Defined:** the start offset is `miss_addr[3:2]` and fetch order wraps (e.g. 2,3,0,1), so `crit_valid` follows the first ack.
  - **Undefined:** the start offset is always 0 (order 0,1,2,3), and `crit_valid` follows the ack of slot `miss_addr[3:2]`, up to 3 acks later.
  - `fill_line` contents and `fill_valid` timing are identical in both builds.

## Test plan
- **Reset:** `rst` pulse with `miss_valid`=1 → `miss_ready`=1, `mem_req`=0, `fill_valid`=0, `crit_valid`=0; no miss is accepted while `rst` is high.
- **Critical-word wrap (macro defined):** miss at 0x12A8, ack every cycle, memory returns the address as data → `mem_addr` sequence 0x12A8, 0x12AC, 0x12A0, 0x12A4; `crit_data`=0x000012A8 one cycle after the first ack; `fill_index`=0xA; `fill_line`={1, 0x12, 0x12AC, 0x12A8, 0x12A4, 0x12A0}.
- **Sequential order (macro undefined):** same stimulus → `mem_addr` sequence 0x12A0, 0x12A4, 0x12A8, 0x12AC; `crit_valid` one cycle after the 3rd ack; identical `fill_line`.
- **Memory stall:** miss at 0x0034 with `mem_ack` low for 3 cycles before each ack → `mem_addr` stable during each stall; `fill_valid` exactly 16 cycles after acceptance; a single-cycle pulse.
- **Reset mid-fetch:** assert `rst` after 2 acks → `mem_req` drops in the same cycle; no `fill_valid`; the next miss at 0x0100 refills cleanly with count restarting at 0.
- **Busy ignore:** `miss_valid` held high with address 0x5550 throughout a refill of 0x4440 → the second miss is accepted only on the edge after `fill_valid`; its `mem_addr` starts at 0x5550.
